spi_regfile_periph: RTL and testbench
=====================================

// Module: spi_regfile_periph
// PURPOSE
//  SPI mode-0 peripheral exposing a parametrised bank of read/write config registers to the chip.
//  Replaces the fixed 5-register write-only SPI block with configurable address/data width, register count and SPI read-back on CIPO.
//  Adds write strobes and error reporting.
//  Sits between the top-level SPI pins and the output-enable/PWM logic; all logic runs in the clk domain.
// PARAMETERS
//  SYNC   2  synchroniser depth for nCS/SCLK/COPI, >=2
//  AW     7  address field width, bits
//  DW     8  register/data field width, bits
//  NREGS  5  implemented registers, addresses 0..NREGS-1; 1 <= NREGS <= 2**AW
// PORTS
//  clk       in   1         system clock; must be >= 8x SCLK frequency
//  rst_n     in   1         asynchronous reset, active-low
//  nCS       in   1         SPI chip select, active-low, async to clk
//  SCLK      in   1         SPI clock, async to clk, idle low (CPOL=0)
//  COPI      in   1         SPI controller-out data
//  CIPO      out  1         SPI peripheral-out data
//  cipo_oe   out  1         high while the synchronised nCS is low; drives pad output enable
//  regs_out  out  NREGS*DW  register bank, reg k at [k*DW +: DW]
//  wr_stb    out  1         1-cycle pulse on every committed write
//  wr_addr   out  AW        address of the last committed write
//  bad_addr  out  1         1-cycle pulse when a frame addresses reg >= NREGS
//  abort     out  1         1-cycle pulse when nCS deasserts mid-frame
// BEHAVIOUR
//  - Reset values:
//    - nCS synchroniser resets to all-1s; SCLK/COPI synchronisers reset to 0.
//    - All regs, CIPO, cipo_oe, wr_stb, wr_addr, bad_addr and abort reset to 0.
//    - FSM resets to IDLE.
//  - Frame: 1+AW+DW bits, MSB first: [RW][ADDR AW-1:0][DATA DW-1:0]. RW=1 write, RW=0 read.
//  - Edges are detected on the last two synchroniser taps: 01 = rise, 10 = fall. The same applies to nCS.
//  - COPI is sampled from the last synchroniser tap in the clk cycle where an SCLK rise is detected.
//  - FSM:
//    - IDLE: nCS fall -> HDR; bit counter cleared.
//    - HDR: shifts in RW+ADDR.
//      - After bit 1+AW -> DATA.
//      - On read, the shadow shifter loads reg[ADDR] in that same cycle; the load is 0 if ADDR >= NREGS.
//    - DATA: shifts in DW bits.
//      - After the last bit -> DONE.
//      - On a write, the target reg is updated 1 clk after the last-bit sample; wr_stb and wr_addr are valid in that same cycle.
//      - Writes to ADDR >= NREGS change no register, give no wr_stb, and pulse bad_addr instead.
//      - Reads from ADDR >= NREGS also pulse bad_addr, 1 clk after the last address bit.
//    - DONE: further SCLK edges are ignored; nCS rise -> IDLE.
//    - nCS rise in HDR or DATA -> IDLE, abort pulses for 1 clk, no register changes.
//    - nCS fall while not IDLE (glitch) restarts at HDR.
//  - CIPO:
//    - On read, the shadow MSB appears 1 clk after the load.
//    - Shadow shifts left on each detected SCLK fall in DATA, filling with 0.
//    - CIPO is 0 on write frames and outside DATA.
//  - Simultaneous SCLK rise and nCS rise in the same clk: the nCS rise wins and the bit is discarded.
//  - Bit counter width is clog2(1+AW+DW+1); it saturates in DONE and never wraps.
//  - Read data is captured at address completion, so a concurrent write cannot corrupt an in-flight read.
//  - rst_n assertion mid-frame returns everything to reset values immediately.
//    - After release, the FSM stays IDLE until the next nCS fall; the partial frame is lost.
// TESTING
//  1. Write 0xA5 to addr 2 (frame 0x82A5) -> regs_out[23:16]=0xA5, wr_stb pulses once, wr_addr=2, other regs 0.
//  2. Write 0x3C to addr 4, then read addr 4 (frame 0x0400) -> CIPO shifts 0011_1100 MSB first; no wr_stb on the read.
//  3. Write to addr 5 with NREGS=5 (frame 0x85FF) -> bad_addr pulses, no wr_stb, all regs unchanged.
//  4. nCS rises after 10 SCLK of a write to addr 0 -> abort pulses, reg0 unchanged; next full write to addr 0 succeeds.
//  5. 20 SCLK pulses in one frame writing 0x11 to addr 1 -> reg1=0x11, extra edges ignored, exactly one wr_stb.
//  6. rst_n pulsed low mid-DATA after 0xFF was written to addr 3 -> all outputs 0, reg3=0x00.
//     A following frame writing 0x77 to addr 3 then gives reg3=0x77.
//     Rerun scenarios 1-2 with AW=4, DW=16, NREGS=16.

Source files
------------

// File: rtl/spi_regfile_periph.sv
// rtl/spi_regfile_periph.sv - SPI mode-0 peripheral with a read/write config register bank
module spi_regfile_periph #(
  parameter int SYNC  = 2,
  parameter int AW    = 7,
  parameter int DW    = 8,
  parameter int NREGS = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                nCS,
  input  logic                SCLK,
  input  logic                COPI,
  output logic                CIPO,
  output logic                cipo_oe,
  output logic [NREGS*DW-1:0] regs_out,
  output logic                wr_stb,
  output logic [AW-1:0]       wr_addr,
  output logic                bad_addr,
  output logic                abort
);

  localparam int FL = 1 + AW + DW;
  localparam int CW = $clog2(FL + 1);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [SYNC-1:0] r_ncs_sync, r_sclk_sync, r_copi_sync;
  logic [CW-1:0]   r_cnt;
  logic [AW:0]     r_hdr;
  logic [DW-2:0]   r_data;
  logic [DW-1:0]   r_shadow;
  logic [DW-1:0]   r_regs [NREGS];
  logic            r_cipo, r_wr_stb, r_bad, r_abort;
  logic [AW-1:0]   r_wr_addr;

  logic            w_ncs_fall, w_ncs_rise, w_sclk_rise, w_sclk_fall, w_copi;
  logic [AW:0]     w_hdr_full;
  logic [DW-1:0]   w_data_full, w_rd_data;
  logic            w_rd_hit, w_wr_hit;
  logic            w_clr, w_cnt_inc, w_hdr_shift, w_data_shift, w_load, w_shd_shift;
  logic            w_wr, w_bad, w_abort;

  // Bring the asynchronous SPI pins into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ncs_sync  <= '1;
      r_sclk_sync <= '0;
      r_copi_sync <= '0;
    end else begin
      r_ncs_sync  <= {r_ncs_sync[SYNC-2:0], nCS};
      r_sclk_sync <= {r_sclk_sync[SYNC-2:0], SCLK};
      r_copi_sync <= {r_copi_sync[SYNC-2:0], COPI};
    end
  end

  assign w_ncs_fall  =  r_ncs_sync[SYNC-1]  & ~r_ncs_sync[SYNC-2];
  assign w_ncs_rise  = ~r_ncs_sync[SYNC-1]  &  r_ncs_sync[SYNC-2];
  assign w_sclk_rise = ~r_sclk_sync[SYNC-1] &  r_sclk_sync[SYNC-2];
  assign w_sclk_fall =  r_sclk_sync[SYNC-1] & ~r_sclk_sync[SYNC-2];
  assign w_copi      =  r_copi_sync[SYNC-1];
  assign w_hdr_full  = {r_hdr[AW-1:0], w_copi};
  assign w_data_full = {r_data, w_copi};

  // Address decode: read lookup on the completing header, write hit on the latched header
  always_comb begin
    w_rd_hit  = 1'b0;
    w_rd_data = '0;
    w_wr_hit  = 1'b0;
    for (int k = 0; k < NREGS; k++) begin
      if (w_hdr_full[AW-1:0] == AW'(k)) begin
        w_rd_hit  = 1'b1;
        w_rd_data = r_regs[k];
      end
      if (r_hdr[AW-1:0] == AW'(k)) w_wr_hit = 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state and per-cycle actions; an nCS edge takes priority over any SCLK edge
  always_comb begin
    w_next       = r_state;
    w_clr        = 1'b0;
    w_cnt_inc    = 1'b0;
    w_hdr_shift  = 1'b0;
    w_data_shift = 1'b0;
    w_load       = 1'b0;
    w_shd_shift  = 1'b0;
    w_wr         = 1'b0;
    w_bad        = 1'b0;
    w_abort      = 1'b0;
    if (w_ncs_fall) begin
      w_next = S_HDR;
      w_clr  = 1'b1;
    end else if (w_ncs_rise) begin
      w_next  = S_IDLE;
      w_abort = (r_state == S_HDR) || (r_state == S_DATA);
    end else begin
      case (r_state)
        S_HDR: begin
          if (w_sclk_rise) begin
            w_hdr_shift = 1'b1;
            w_cnt_inc   = 1'b1;
            if (r_cnt == CW'(AW)) begin
              w_next = S_DATA;
              if (!w_hdr_full[AW]) begin
                w_load = 1'b1;
                w_bad  = ~w_rd_hit;
              end
            end
          end
        end
        S_DATA: begin
          if (w_sclk_rise) begin
            w_data_shift = 1'b1;
            w_cnt_inc    = 1'b1;
            if (r_cnt == CW'(FL - 1)) begin
              w_next = S_DONE;
              if (r_hdr[AW]) begin
                w_wr  = w_wr_hit;
                w_bad = ~w_wr_hit;
              end
            end
          end
          if (w_sclk_fall && !r_hdr[AW]) w_shd_shift = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Shift registers, register bank, CIPO and status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_hdr     <= '0;
      r_data    <= '0;
      r_shadow  <= '0;
      r_cipo    <= 1'b0;
      r_wr_stb  <= 1'b0;
      r_bad     <= 1'b0;
      r_abort   <= 1'b0;
      r_wr_addr <= '0;
      for (int k = 0; k < NREGS; k++) r_regs[k] <= '0;
    end else begin
      r_wr_stb <= w_wr;
      r_bad    <= w_bad;
      r_abort  <= w_abort;
      if (w_clr)          r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + CW'(1);
      if (w_hdr_shift)  r_hdr  <= w_hdr_full;
      if (w_data_shift) r_data <= w_data_full[DW-2:0];
      if (w_load)           r_shadow <= w_rd_hit ? w_rd_data : '0;
      else if (w_shd_shift) r_shadow <= {r_shadow[DW-2:0], 1'b0};
      if (w_wr) begin
        r_wr_addr <= r_hdr[AW-1:0];
        for (int k = 0; k < NREGS; k++)
          if (r_hdr[AW-1:0] == AW'(k)) r_regs[k] <= w_data_full;
      end
      r_cipo <= ((r_state == S_DATA) && !r_hdr[AW]) ? r_shadow[DW-1] : 1'b0;
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_out
    assign regs_out[g*DW +: DW] = r_regs[g];
  end

  assign CIPO     = r_cipo;
  assign cipo_oe  = ~r_ncs_sync[SYNC-1];
  assign wr_stb   = r_wr_stb;
  assign wr_addr  = r_wr_addr;
  assign bad_addr = r_bad;
  assign abort    = r_abort;

endmodule

// File: tb/tb_spi_regfile_periph.sv
// tb/tb_spi_regfile_periph.sv - self-checking bench for spi_regfile_periph
module tb_spi_regfile_periph;

  localparam int HALF = 8;

  logic clk, rst_n;
  logic tb_ncs, tb_sclk, tb_copi, tb_sel;

  logic          ncs0, sclk0, copi0, cipo0, oe0, wr_stb0, bad0, abort0;
  logic [39:0]   regs0;
  logic [6:0]    wr_addr0;
  logic          ncs1, sclk1, copi1, cipo1, oe1, wr_stb1, bad1, abort1;
  logic [255:0]  regs1;
  logic [3:0]    wr_addr1;

  assign ncs0  = tb_sel ? 1'b1 : tb_ncs;
  assign sclk0 = tb_sel ? 1'b0 : tb_sclk;
  assign copi0 = tb_sel ? 1'b0 : tb_copi;
  assign ncs1  = tb_sel ? tb_ncs  : 1'b1;
  assign sclk1 = tb_sel ? tb_sclk : 1'b0;
  assign copi1 = tb_sel ? tb_copi : 1'b0;

  spi_regfile_periph dut0 (
    .clk(clk), .rst_n(rst_n), .nCS(ncs0), .SCLK(sclk0), .COPI(copi0),
    .CIPO(cipo0), .cipo_oe(oe0), .regs_out(regs0), .wr_stb(wr_stb0),
    .wr_addr(wr_addr0), .bad_addr(bad0), .abort(abort0)
  );

  spi_regfile_periph #(.AW(4), .DW(16), .NREGS(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .nCS(ncs1), .SCLK(sclk1), .COPI(copi1),
    .CIPO(cipo1), .cipo_oe(oe1), .regs_out(regs1), .wr_stb(wr_stb1),
    .wr_addr(wr_addr1), .bad_addr(bad1), .abort(abort1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_wr0 = 0, n_bad0 = 0, n_abort0 = 0, n_wr1 = 0, n_bad1 = 0, n_abort1 = 0;
  always @(posedge clk) begin
    if (wr_stb0) n_wr0 <= n_wr0 + 1;
    if (bad0)    n_bad0 <= n_bad0 + 1;
    if (abort0)  n_abort0 <= n_abort0 + 1;
    if (wr_stb1) n_wr1 <= n_wr1 + 1;
    if (bad1)    n_bad1 <= n_bad1 + 1;
    if (abort1)  n_abort1 <= n_abort1 + 1;
  end

  int checks = 0;
  int failures = 0;
  logic [15:0] m [2][16];
  logic last_oe;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input int which, input string tag);
    logic [255:0] e;
    e = '0;
    if (which == 0) begin
      for (int k = 0; k < 5; k++) e[k*8 +: 8] = m[0][k][7:0];
      chk({tag, ":regs"}, 256'(regs0), e);
    end else begin
      for (int k = 0; k < 16; k++) e[k*16 +: 16] = m[1][k];
      chk({tag, ":regs"}, regs1, e);
    end
  endtask

  task automatic cs_low();
    @(negedge clk);
    tb_ncs = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  // COPI set while SCLK low; CIPO sampled at the end of the high phase
  task automatic clk_bit(input logic b, output logic so);
    tb_copi = b;
    repeat (HALF) @(negedge clk);
    tb_sclk = 1'b1;
    repeat (HALF) @(negedge clk);
    so = tb_sel ? cipo1 : cipo0;
    last_oe = tb_sel ? oe1 : oe0;
    tb_sclk = 1'b0;
  endtask

  task automatic cs_high();
    repeat (HALF) @(negedge clk);
    tb_ncs = 1'b1;
    repeat (2*HALF) @(negedge clk);
  endtask

  task automatic frame(input logic [63:0] bits, input int n, output logic [63:0] miso);
    logic so;
    miso = '0;
    cs_low();
    for (int i = n - 1; i >= 0; i--) begin
      clk_bit(bits[i], so);
      miso[i] = so;
    end
    cs_high();
  endtask

  // One complete frame checked against the register-bank model
  task automatic txn(input int which, input logic rw, input int addr, input logic [15:0] data,
                     input string tag);
    int aw, dw, nr, wr_b, bad_b, ab_b, d_wr, d_bad, d_ab;
    logic [15:0] mask;
    logic [63:0] fb, miso, exp_miso;
    logic ok;
    aw = (which != 0) ? 4 : 7;
    dw = (which != 0) ? 16 : 8;
    nr = (which != 0) ? 16 : 5;
    mask = (which != 0) ? 16'hFFFF : 16'h00FF;
    tb_sel = (which != 0);
    fb = (64'(rw) << (aw + dw)) | (64'(addr) << dw) | 64'(data & mask);
    wr_b  = (which != 0) ? n_wr1 : n_wr0;
    bad_b = (which != 0) ? n_bad1 : n_bad0;
    ab_b  = (which != 0) ? n_abort1 : n_abort0;
    frame(fb, 1 + aw + dw, miso);
    d_wr  = ((which != 0) ? n_wr1 : n_wr0) - wr_b;
    d_bad = ((which != 0) ? n_bad1 : n_bad0) - bad_b;
    d_ab  = ((which != 0) ? n_abort1 : n_abort0) - ab_b;
    ok = (addr < nr);
    if (rw) begin
      if (ok) m[which][addr] = data & mask;
      exp_miso = '0;
    end else begin
      exp_miso = 64'(ok ? m[which][addr] : 16'h0) << 1;
    end
    chk({tag, ":cipo"}, 256'(miso), 256'(exp_miso));
    chk({tag, ":oe"}, 256'(last_oe), 256'(1'b1));
    chk({tag, ":wr_stb"}, 256'(d_wr), 256'((rw && ok) ? 1 : 0));
    chk({tag, ":bad"}, 256'(d_bad), 256'(ok ? 0 : 1));
    chk({tag, ":abort"}, 256'(d_ab), 256'(0));
    if (rw && ok)
      chk({tag, ":wr_addr"}, 256'((which != 0) ? 7'(wr_addr1) : wr_addr0), 256'(addr));
    chk_regs(which, tag);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] miso;
    logic so;
    int b;
    for (int w = 0; w < 2; w++) for (int k = 0; k < 16; k++) m[w][k] = '0;
    rst_n = 1'b0; tb_ncs = 1'b1; tb_sclk = 1'b0; tb_copi = 1'b0; tb_sel = 1'b0; last_oe = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst:regs0", 256'(regs0), 256'(0));
    chk("rst:cipo0", 256'(cipo0), 256'(0));
    chk("rst:oe0", 256'(oe0), 256'(0));
    chk("rst:pulses0", 256'({wr_stb0, bad0, abort0}), 256'(0));
    chk("rst:wr_addr0", 256'(wr_addr0), 256'(0));
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    txn(0, 1'b1, 2, 16'hA5, "t1_wr_a5");
    chk("t1:oe_idle", 256'(oe0), 256'(0));
    txn(0, 1'b1, 4, 16'h3C, "t2_wr_3c");
    txn(0, 1'b0, 4, 16'h00, "t2_rd_3c");
    txn(0, 1'b1, 5, 16'hFF, "t3_bad_wr");
    txn(0, 1'b0, 6, 16'h00, "t3_bad_rd");

    // Abort after 10 SCLK of a write to addr 0
    b = n_abort0;
    frame(64'h805A >> 6, 10, miso);
    chk("t4:abort", 256'(n_abort0 - b), 256'(1));
    chk_regs(0, "t4");
    txn(0, 1'b1, 0, 16'h5A, "t4_retry");

    // 20 SCLK pulses: four trailing edges must be ignored
    b = n_wr0;
    frame({44'h0, 16'h8111, 4'h0}, 20, miso);
    m[0][1] = 16'h11;
    chk("t5:wr_count", 256'(n_wr0 - b), 256'(1));
    chk_regs(0, "t5");

    for (int t = 0; t < 14; t++)
      txn(0, 1'($urandom_range(0, 1)), $urandom_range(0, 6), 16'($urandom), "rnd0");

    // Reset mid-DATA after 0xFF written to addr 3
    txn(0, 1'b1, 3, 16'hFF, "t6_wr_ff");
    cs_low();
    for (int i = 15; i >= 4; i--) begin
      logic [15:0] fr;
      fr = 16'h8142;
      clk_bit(fr[i], so);
    end
    @(negedge clk);
    rst_n = 1'b0; tb_ncs = 1'b1; tb_sclk = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6:regs0", 256'(regs0), 256'(0));
    chk("t6:outs0", 256'({cipo0, oe0, wr_stb0, bad0, abort0}), 256'(0));
    chk("t6:wr_addr0", 256'(wr_addr0), 256'(0));
    rst_n = 1'b1;
    for (int w = 0; w < 2; w++) for (int k = 0; k < 16; k++) m[w][k] = '0;
    repeat (4) @(negedge clk);
    txn(0, 1'b1, 3, 16'h77, "t6_wr_77");

    txn(1, 1'b1, 2, 16'hBEEF, "w1_wr");
    txn(1, 1'b1, 4, 16'h3C5A, "w2_wr");
    txn(1, 1'b0, 4, 16'h0, "w2_rd");
    txn(1, 1'b1, 15, 16'h8001, "w_top_wr");
    txn(1, 1'b0, 15, 16'h0, "w_top_rd");
    for (int t = 0; t < 8; t++)
      txn(1, 1'($urandom_range(0, 1)), $urandom_range(0, 15), 16'($urandom), "rnd1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
